// File: rtl/bmp_pixel_source.sv
// Purpose: walks a bottom-up BMP pixel array in byte-wide memory and streams 24-bit pixels with hsync/vsync markers.
// Latency: first pix_valid 5 cycles after start is sampled; one pixel per 5 cycles at best; frame_done follows the last transfer.
// Backpressure: pix_ready low holds pix_valid, pix_data, hsync and vsync stable; no memory reads are issued while stalled.
module bmp_pixel_source #(
    parameter int PIXEL_SIZE = 24,
    parameter int WORD_SIZE  = 8,
    parameter int ADDR_W     = 21,
    parameter int DIM_W      = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [DIM_W-1:0]      width,
    input  logic [DIM_W-1:0]      height,
    input  logic [1:0]            padding,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [WORD_SIZE-1:0]  mem_rdata,
    input  logic                  pix_ready,
    output logic                  pix_valid,
    output logic [PIXEL_SIZE-1:0] pix_data,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  busy,
    output logic                  frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_CAP,
        S_OUT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DIM_W-1:0]      width_q, width_d;
    logic [DIM_W-1:0]      height_q, height_d;
    logic [1:0]            pad_q, pad_d;
    logic [ADDR_W-1:0]     ptr_q, ptr_d;
    logic [DIM_W-1:0]      x_q, x_d;
    logic [DIM_W-1:0]      y_q, y_d;
    logic [WORD_SIZE-1:0]  byte0_q, byte0_d;
    logic [WORD_SIZE-1:0]  byte1_q, byte1_d;
    logic                  mem_en_q, mem_en_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic                  pix_valid_q, pix_valid_d;
    logic [PIXEL_SIZE-1:0] pix_data_q, pix_data_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;

    logic                  row_end;
    logic                  last_pix;
    logic                  xfer;
    logic [ADDR_W-1:0]     ptr_next;

    // Position decode and next pixel address; row wrap also skips the row padding.
    always_comb begin
        row_end  = (x_q == width_q - DIM_W'(1));
        last_pix = row_end && (y_q == height_q - DIM_W'(1));
        xfer     = pix_valid_q && pix_ready;
        if (row_end) begin
            ptr_next = ptr_q + ADDR_W'(3) + ADDR_W'(pad_q);
        end else begin
            ptr_next = ptr_q + ADDR_W'(3);
        end
    end

    // Next-state logic; outputs are computed for the state being entered so they appear registered.
    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        height_d     = height_q;
        pad_d        = pad_q;
        ptr_d        = ptr_q;
        x_d          = x_q;
        y_d          = y_q;
        byte0_d      = byte0_q;
        byte1_d      = byte1_q;
        mem_en_d     = mem_en_q;
        mem_addr_d   = mem_addr_q;
        pix_valid_d  = pix_valid_q;
        pix_data_d   = pix_data_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    width_d  = width;
                    height_d = height;
                    pad_d    = padding;
                    ptr_d    = base_addr;
                    x_d      = '0;
                    y_d      = '0;
                    busy_d   = 1'b1;
                    if ((width == '0) || (height == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_RD0;
                        mem_en_d   = 1'b1;
                        mem_addr_d = base_addr;
                    end
                end
            end
            S_RD0: begin
                mem_addr_d = ptr_q + ADDR_W'(1);
                state_d    = S_RD1;
            end
            S_RD1: begin
                // Data for ptr+0 arrives one cycle after its strobe.
                byte0_d    = mem_rdata;
                mem_addr_d = ptr_q + ADDR_W'(2);
                state_d    = S_RD2;
            end
            S_RD2: begin
                byte1_d  = mem_rdata;
                mem_en_d = 1'b0;
                state_d  = S_CAP;
            end
            S_CAP: begin
                pix_data_d  = PIXEL_SIZE'({mem_rdata, byte1_q, byte0_q});
                hsync_d     = (x_q == '0);
                vsync_d     = (x_q == '0) && (y_q == '0);
                pix_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (xfer) begin
                    pix_valid_d = 1'b0;
                    hsync_d     = 1'b0;
                    vsync_d     = 1'b0;
                    if (last_pix) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d      = ptr_next;
                        mem_en_d   = 1'b1;
                        mem_addr_d = ptr_next;
                        state_d    = S_RD0;
                        if (row_end) begin
                            x_d = '0;
                            y_d = y_q + DIM_W'(1);
                        end else begin
                            x_d = x_q + DIM_W'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight without a frame_done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            width_q      <= '0;
            height_q     <= '0;
            pad_q        <= '0;
            ptr_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            byte0_q      <= '0;
            byte1_q      <= '0;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= '0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            pad_q        <= pad_d;
            ptr_q        <= ptr_d;
            x_q          <= x_d;
            y_q          <= y_d;
            byte0_q      <= byte0_d;
            byte1_q      <= byte1_d;
            mem_en_q     <= mem_en_d;
            mem_addr_q   <= mem_addr_d;
            pix_valid_q  <= pix_valid_d;
            pix_data_q   <= pix_data_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_addr   = mem_addr_q;
    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bmp_pixel_source.sv
// Purpose: randomized and directed frames against a frame-level pixel reference model.
// Latency: checks first-pixel, frame_done and full-frame cycle counts.
// Backpressure: random, directed-stall and held-low pix_ready patterns.
module tb_bmp_pixel_source;

    localparam int ADDR_W = 21;
    localparam int DIM_W  = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [DIM_W-1:0]  width;
    logic [DIM_W-1:0]  height;
    logic [1:0]        padding;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              pix_ready;
    logic              pix_valid;
    logic [23:0]       pix_data;
    logic              hsync;
    logic              vsync;
    logic              busy;
    logic              frame_done;

    always #5 clk = ~clk;

    bmp_pixel_source #(
        .PIXEL_SIZE(24),
        .WORD_SIZE (8),
        .ADDR_W    (ADDR_W),
        .DIM_W     (DIM_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .width     (width),
        .height    (height),
        .padding   (padding),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .pix_ready (pix_ready),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .hsync     (hsync),
        .vsync     (vsync),
        .busy      (busy),
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic [23:0] dat;
        logic        hs;
        logic        vs;
    } pix_t;

    pix_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int xfer_cnt, fdone_cnt, men_cnt, pv_cnt;
    int first_valid_cyc, fdone_cyc, last_xfer_cyc, start_cyc, exp_total;
    int rdy_mode   = 0;
    int stall_left = 0;

    logic              prev_stall = 1'b0;
    logic [23:0]       prev_dat   = '0;
    logic [1:0]        prev_sync  = '0;
    logic [ADDR_W-1:0] prev_addr  = '0;
    logic [7:0]        mem_seed   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ mem_seed;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory: data one cycle after the strobe, junk when not strobed.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem_byte(mem_addr);
        else        mem_rdata <= 8'($urandom);
    end

    // Frame model: row y, column x lives at base + y*(3*w+pad) + 3*x, little-endian bytes.
    task automatic build_exp(input logic [ADDR_W-1:0] b, input int w, input int h, input int p);
        exp_q.delete();
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                logic [ADDR_W-1:0] a;
                pix_t e;
                a     = b + ADDR_W'(y * (3 * w + p) + 3 * x);
                e.dat = {mem_byte(a + ADDR_W'(2)), mem_byte(a + ADDR_W'(1)), mem_byte(a)};
                e.hs  = (x == 0);
                e.vs  = (x == 0) && (y == 0);
                exp_q.push_back(e);
            end
        end
        exp_total = w * h;
    endtask

    task automatic clear_counts();
        xfer_cnt        = 0;
        fdone_cnt       = 0;
        men_cnt         = 0;
        pv_cnt          = 0;
        first_valid_cyc = -1;
        fdone_cyc       = -1;
        last_xfer_cyc   = -1;
    endtask

    // pix_ready driver: 0 always ready, 1 random, 2 held low, 3 stall 7 cycles on the second pixel.
    initial begin
        pix_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: pix_ready = 1'b1;
                1: pix_ready = 1'($urandom_range(0, 1));
                2: pix_ready = 1'b0;
                default: begin
                    if (pix_valid && xfer_cnt == 1 && stall_left > 0) begin
                        pix_ready = 1'b0;
                        stall_left--;
                    end else begin
                        pix_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
            prev_addr  = '0;
        end else begin
            chk("men_during_valid", 32'(mem_en & pix_valid), 32'd0);
            if (!mem_en) chk("addr_hold", 32'(mem_addr), 32'(prev_addr));
            if (prev_stall) begin
                chk("stall_valid", 32'(pix_valid), 32'd1);
                chk("stall_dat", 32'(pix_data), 32'(prev_dat));
                chk("stall_sync", 32'({hsync, vsync}), 32'(prev_sync));
            end
            if (mem_en) men_cnt++;
            if (pix_valid) begin
                pv_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (frame_done) begin
                fdone_cnt++;
                fdone_cyc = cyc;
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pix_count", xfer_cnt + 1, exp_total);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    chk("pix_dat", 32'(pix_data), 32'(e.dat));
                    chk("pix_sync", 32'({hsync, vsync}), 32'({e.hs, e.vs}));
                end
                xfer_cnt++;
                last_xfer_cyc = cyc;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_dat   = pix_data;
            prev_sync  = {hsync, vsync};
            prev_addr  = mem_addr;
        end
    end

    task automatic run_frame(input logic [ADDR_W-1:0] b, input int w, input int h, input int p,
                             input logic [7:0] seed, input int rmode, input bit poke_busy);
        int t;
        mem_seed = seed;
        build_exp(b, w, h, p);
        clear_counts();
        rdy_mode   = rmode;
        stall_left = 7;
        @(posedge clk);
        #1;
        base_addr = b;
        width     = DIM_W'(w);
        height    = DIM_W'(h);
        padding   = 2'(p);
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start     = poke_busy;
        base_addr = ADDR_W'($urandom);
        width     = DIM_W'($urandom_range(1, 9));
        height    = DIM_W'($urandom_range(1, 9));
        padding   = 2'($urandom);
        @(posedge clk);
        #1;
        start = 1'b0;
        t = 0;
        while (fdone_cnt == 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk("frame_timeout", 32'(t < 3000), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("fdone_cnt", fdone_cnt, 1);
        chk("pix_left", exp_q.size(), 0);
        chk("xfer_cnt", xfer_cnt, w * h);
        chk("busy_end", 32'(busy), 32'd0);
        if (w * h > 0) begin
            chk("lat_first", first_valid_cyc - start_cyc, 5);
            chk("lat_done", fdone_cyc - last_xfer_cyc, 2);
            if (rmode == 0) chk("lat_frame", fdone_cyc - start_cyc, 5 * w * h + 2);
        end else begin
            chk("deg_no_men", men_cnt, 0);
            chk("deg_no_valid", pv_cnt, 0);
            chk("deg_lat", fdone_cyc - start_cyc, 2);
        end
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        width     = '0;
        height    = '0;
        padding   = '0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({mem_en, pix_valid, hsync, vsync, busy, frame_done}), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_dat", 32'(pix_data), 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // 2x2 frame, padding 2, memory = address low byte.
        run_frame(21'h100, 2, 2, 2, 8'h00, 0, 1'b0);
        // Same frame, 7-cycle stall on the second pixel.
        run_frame(21'h100, 2, 2, 2, 8'h00, 3, 1'b0);
        // 1x1 frame latency.
        run_frame(21'h040, 1, 1, 0, 8'h5A, 0, 1'b0);
        // Degenerate frames, start held into the busy cycle.
        run_frame(21'h200, 0, 5, 1, 8'h00, 0, 1'b1);
        run_frame(21'h300, 3, 0, 3, 8'h00, 0, 1'b1);

        // Abort mid-frame while stalled in OUT.
        mem_seed = 8'h33;
        build_exp(21'h500, 3, 2, 1);
        clear_counts();
        rdy_mode = 2;
        @(posedge clk);
        #1;
        base_addr = 21'h500;
        width     = 12'd3;
        height    = 12'd2;
        padding   = 2'd1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t = 0;
        while (!pix_valid && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("abort_reach_out", 32'(pix_valid), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_valid", 32'(pix_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_men", 32'(mem_en), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", fdone_cnt, 0);
        run_frame(21'h600, 2, 3, 1, 8'hC3, 0, 1'b1);

        // Randomized frames, including address wrap at the top of memory.
        for (int i = 0; i < 10; i++) begin
            logic [ADDR_W-1:0] b;
            if ($urandom_range(0, 2) == 0) b = 21'h1FFFFF - ADDR_W'($urandom_range(0, 12));
            else                           b = ADDR_W'($urandom);
            run_frame(b, $urandom_range(1, 4), $urandom_range(1, 3), $urandom_range(0, 3),
                      8'($urandom), (i % 3 == 0) ? 0 : 1, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
